// File: rtl/pb_step_counter.sv
// pb_step_counter: push-button driven up/down counter with slow/fast stepping.
// A held button steps by 1 on each start or repeat pulse. After FAST_AFTER
// repeat pulses within one press it steps by FAST_STEP on each repeat pulse.
// The count saturates at 0 and at MAX_VAL.
module pb_step_counter #(
  parameter logic [7:0] MAX_VAL    = 8'd200,
  parameter logic [3:0] FAST_AFTER = 4'd8,
  parameter logic [7:0] FAST_STEP  = 8'd4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLR,
  input  logic       UP_DPB,
  input  logic       DN_DPB,
  input  logic       UP_SCEN,
  input  logic       DN_SCEN,
  input  logic       UP_MCEN,
  input  logic       DN_MCEN,
  output logic [7:0] VALUE,
  output logic       AT_MAX,
  output logic       AT_MIN,
  output logic       FAST
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOW = 2'd1,
    ST_FAST = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] rpt_cnt_reg, rpt_cnt_next;
  logic       dir_reg, dir_next;
  logic [7:0] value_reg, value_next;
  logic       at_max_reg, at_min_reg, fast_reg;

  logic       one_held;
  logic       scen_dir;
  logic       mcen_dir;
  logic [3:0] rpt_cnt_inc;
  logic       step_en;
  logic [7:0] step_amt;
  logic [8:0] sum_up;

  // Press qualification, pulse selection by latched direction, and saturating repeat count.
  always_comb begin
    one_held    = UP_DPB ^ DN_DPB;
    scen_dir    = dir_reg ? UP_SCEN : DN_SCEN;
    mcen_dir    = dir_reg ? UP_MCEN : DN_MCEN;
    rpt_cnt_inc = (rpt_cnt_reg == 4'hF) ? 4'hF : rpt_cnt_reg + 4'd1;
  end

  // Next-state logic: decides the step for this cycle and the mode transitions.
  always_comb begin
    state_next   = state_reg;
    rpt_cnt_next = rpt_cnt_reg;
    dir_next     = dir_reg;
    step_en      = 1'b0;
    step_amt     = 8'd1;
    case (state_reg)
      ST_IDLE: begin
        // A new press only arms the FSM; pulses in this cycle do not step.
        if (one_held) begin
          state_next   = ST_SLOW;
          rpt_cnt_next = 4'd0;
          dir_next     = UP_DPB;
        end
      end
      ST_SLOW: begin
        if (!one_held) begin
          state_next = ST_IDLE;
        end else begin
          // Start and repeat pulses may coincide; they still make a single step.
          step_en = scen_dir | mcen_dir;
          if (mcen_dir) begin
            rpt_cnt_next = rpt_cnt_inc;
            if (rpt_cnt_inc == FAST_AFTER) begin
              state_next = ST_FAST;
            end
          end
        end
      end
      ST_FAST: begin
        if (!one_held) begin
          state_next = ST_IDLE;
        end else begin
          step_en  = mcen_dir;
          step_amt = FAST_STEP;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Saturating value update; clear overrides any step.
  always_comb begin
    sum_up     = {1'b0, value_reg} + {1'b0, step_amt};
    value_next = value_reg;
    if (CLR) begin
      value_next = 8'd0;
    end else if (step_en) begin
      if (dir_reg) begin
        value_next = (sum_up > {1'b0, MAX_VAL}) ? MAX_VAL : sum_up[7:0];
      end else begin
        value_next = (value_reg < step_amt) ? 8'd0 : value_reg - step_amt;
      end
    end
  end

  // State, counter and output registers; flags are derived from the next value
  // so they change in the same cycle as VALUE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= ST_IDLE;
      rpt_cnt_reg <= 4'd0;
      dir_reg     <= 1'b1;
      value_reg   <= 8'd0;
      at_max_reg  <= 1'b0;
      at_min_reg  <= 1'b1;
      fast_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rpt_cnt_reg <= rpt_cnt_next;
      dir_reg     <= dir_next;
      value_reg   <= value_next;
      at_max_reg  <= (value_next == MAX_VAL);
      at_min_reg  <= (value_next == 8'd0);
      fast_reg    <= (state_next == ST_FAST);
    end
  end

  assign VALUE  = value_reg;
  assign AT_MAX = at_max_reg;
  assign AT_MIN = at_min_reg;
  assign FAST   = fast_reg;

endmodule
